// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_pkg                                              |
// | Purpose  : Shared UART types and constants for the RX/TX paths.  |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic int clks_per_bit(input int clk, input int baud);
        return clk / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_rx_byte                                          |
// | Purpose  : 8N1 byte receiver: synchroniser, byte FSM, frame_err. |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] byte_data,
    output logic       byte_strobe,
    output logic       frame_err,
    output logic       rx_idle
);

    localparam int                  c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_LD = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_LD = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [2:0]         c_LAST_BIT = 3'(DATA_BITS - 1);

    logic               r_rx_meta;
    logic               r_rx_s;
    logic               r_rx_prev;
    logic [1:0]         r_flush;
    logic               r_armed;
    rx_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_frame_err;

    rx_state_t          w_state_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [2:0]         w_bit_next;
    logic [7:0]         w_shift_next;
    logic               w_strobe;
    logic               w_frame_err;
    logic               w_fall;

    // The synchroniser resets to 1, so its stale contents cannot be trusted
    // until two clocks have flushed it; only then may a high line arm the FSM.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
            r_flush   <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
            r_flush   <= {r_flush[0], 1'b1};
            r_armed   <= r_armed | (r_flush[1] & r_rx_s);
        end
    end

    assign w_fall = r_armed & r_rx_prev & ~r_rx_s;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_next;
            r_shift     <= w_shift_next;
            r_frame_err <= w_frame_err;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_strobe     = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_next = ST_START;
                    w_cnt_next   = c_HALF_LD;
                end
            end
            ST_START: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end else if (!r_rx_s) begin
                    w_state_next = ST_DATA;
                    w_cnt_next   = c_FULL_LD;
                    w_bit_next   = '0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end else begin
                    w_shift_next = {r_rx_s, r_shift[7:1]};
                    w_cnt_next   = c_FULL_LD;
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - c_CNT_ONE;
                end else if (r_rx_s) begin
                    w_strobe     = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_frame_err  = 1'b1;
                    w_state_next = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (r_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign byte_data   = r_shift;
    assign byte_strobe = w_strobe;
    assign frame_err   = r_frame_err;
    assign rx_idle     = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_rx_word.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uart_rx_word                                          |
// | Purpose  : Pairs received UART bytes into 16-bit valid/ready words|
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [15:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        overrun,
    output logic        timeout
);

    localparam int                 c_CPB      = clks_per_bit(CLK_FREQ, BAUD);
    localparam int                 c_TO_LIMIT = TIMEOUT_BITS * c_CPB;
    localparam int                 c_TO_W     = $clog2(c_TO_LIMIT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(c_TO_LIMIT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE   = c_TO_W'(1);

    logic [7:0]        w_byte_data;
    logic              w_byte_strobe;
    logic              w_frame_err;
    logic              w_rx_idle;
    logic              w_word_done;
    logic [15:0]       w_word;

    logic              r_phase;
    logic [7:0]        r_high;
    logic [c_TO_W-1:0] r_tcnt;
    logic              r_timeout;
    logic [15:0]       r_word_data;
    logic              r_word_valid;
    logic              r_overrun;

    uart_rx_byte #(
        .CLKS_PER_BIT (c_CPB)
    ) u_rx_byte (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .byte_data   (w_byte_data),
        .byte_strobe (w_byte_strobe),
        .frame_err   (w_frame_err),
        .rx_idle     (w_rx_idle)
    );

    assign w_word_done = w_byte_strobe & r_phase;
    assign w_word      = {r_high, w_byte_data};

    // The timeout only runs while the line is idle between the two bytes;
    // it freezes as soon as the second byte's start edge is seen.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_phase   <= 1'b0;
            r_high    <= '0;
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (w_frame_err) begin
                r_phase <= 1'b0;
            end else if (w_byte_strobe) begin
                if (!r_phase) begin
                    r_high  <= w_byte_data;
                    r_phase <= 1'b1;
                    r_tcnt  <= '0;
                end else begin
                    r_phase <= 1'b0;
                end
            end else if (r_phase && w_rx_idle) begin
                if (r_tcnt == c_TO_LAST) begin
                    r_timeout <= 1'b1;
                    r_phase   <= 1'b0;
                end else begin
                    r_tcnt <= r_tcnt + c_TO_ONE;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_word_done) begin
                // A word arriving during an accepting handshake replaces it.
                if (!r_word_valid || word_ready) begin
                    r_word_data  <= w_word;
                    r_word_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_word_valid && word_ready) begin
                r_word_valid <= 1'b0;
            end
        end
    end

    assign word_data  = r_word_data;
    assign word_valid = r_word_valid;
    assign frame_err  = w_frame_err;
    assign overrun    = r_overrun;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module   : tb_uart_rx_word                                       |
// | Purpose  : Scoreboard bench for uart_rx_word (64 clocks per bit).|
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_uart_rx_word;

    localparam int CLK_FREQ     = 6400000;
    localparam int BAUD         = 100000;
    localparam int TIMEOUT_BITS = 20;
    localparam int CPB          = 64;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic        word_ready;
    logic [15:0] word_data;
    logic        word_valid;
    logic        frame_err;
    logic        overrun;
    logic        timeout;

    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          n_fe = 0;
    int          n_ov = 0;
    int          n_to = 0;
    int          last_to_cycle = 0;
    logic [15:0] exp_q[$];

    uart_rx_word #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cycle++;

    // Consumer side: every accepted word must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (frame_err) n_fe++;
            if (overrun) n_ov++;
            if (timeout) begin
                n_to++;
                last_to_cycle = cycle;
            end
            if (word_valid && word_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got %h, none expected", word_data);
                end else begin
                    logic [15:0] exp;
                    exp = exp_q.pop_front();
                    if (word_data !== exp) begin
                        failures++;
                        $display("FAIL word_data: got %h, expected %h", word_data, exp);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            uart_rx = frame[i];
            repeat (CPB - 1) @(negedge sys_clk);
        end
    endtask

    task automatic idle_bits(input int n);
        uart_rx = 1'b1;
        repeat (n * CPB) @(negedge sys_clk);
    endtask

    task automatic wait_empty(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 * CPB; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        uart_rx = 1'b1;
        word_ready = 1'b0;
        repeat (5) @(negedge sys_clk);
        checks++; if (word_data !== 16'h0000) begin failures++; $display("FAIL reset_word_data: got %h, expected 0000", word_data); end
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_word_valid: got %b, expected 0", word_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b, expected 0", timeout); end
        rst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_basic;
        int fe0, ov0, to0;
        bit ok;
        fe0 = n_fe; ov0 = n_ov; to0 = n_to;
        word_ready = 1'b1;
        exp_q.push_back(16'h1234);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        wait_empty(ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_drain: queue size %0d, expected 0", exp_q.size()); end
        @(negedge sys_clk);
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle: got %b, expected 0", word_valid); end
        checks++; if (n_fe - fe0 !== 0) begin failures++; $display("FAIL basic_frame_err: got %0d pulses, expected 0", n_fe - fe0); end
        checks++; if (n_ov - ov0 !== 0) begin failures++; $display("FAIL basic_overrun: got %0d pulses, expected 0", n_ov - ov0); end
        checks++; if (n_to - to0 !== 0) begin failures++; $display("FAIL basic_timeout: got %0d pulses, expected 0", n_to - to0); end
        idle_bits(2);
    endtask

    task automatic test_overrun;
        int ov0;
        bit ok;
        ov0 = n_ov;
        word_ready = 1'b0;
        exp_q.push_back(16'hABCD);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        @(negedge sys_clk);
        checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL overrun_valid_held: got %b, expected 1", word_valid); end
        checks++; if (word_data !== 16'hABCD) begin failures++; $display("FAIL overrun_data_held: got %h, expected abcd", word_data); end
        checks++; if (n_ov - ov0 !== 1) begin failures++; $display("FAIL overrun_pulses: got %0d, expected 1", n_ov - ov0); end
        word_ready = 1'b1;
        wait_empty(ok);
        checks++; if (!ok) begin failures++; $display("FAIL overrun_drain: queue size %0d, expected 0", exp_q.size()); end
        @(negedge sys_clk);
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL overrun_valid_fall: got %b, expected 0", word_valid); end
        exp_q.push_back(16'h0102);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_empty(ok);
        checks++; if (!ok) begin failures++; $display("FAIL overrun_next_pair: queue size %0d, expected 0", exp_q.size()); end
        idle_bits(2);
    endtask

    task automatic test_frame_err;
        int fe0, ov0, to0;
        bit ok;
        fe0 = n_fe; ov0 = n_ov; to0 = n_to;
        send_byte(8'h7F, 1'b0);
        idle_bits(2);
        checks++; if (n_fe - fe0 !== 1) begin failures++; $display("FAIL frame_err_pulses: got %0d, expected 1", n_fe - fe0); end
        exp_q.push_back(16'h1122);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_empty(ok);
        checks++; if (!ok) begin failures++; $display("FAIL frame_err_next_pair: queue size %0d, expected 0", exp_q.size()); end
        checks++; if (n_fe - fe0 !== 1) begin failures++; $display("FAIL frame_err_total: got %0d, expected 1", n_fe - fe0); end
        checks++; if ((n_ov - ov0) + (n_to - to0) !== 0) begin failures++; $display("FAIL frame_err_other_pulses: got %0d, expected 0", (n_ov - ov0) + (n_to - to0)); end
        idle_bits(2);
    endtask

    task automatic test_timeout;
        int to0, t_end, dt;
        bit ok;
        to0 = n_to;
        send_byte(8'h99, 1'b1);
        t_end = cycle;
        idle_bits(25);
        checks++; if (n_to - to0 !== 1) begin failures++; $display("FAIL timeout_pulses: got %0d, expected 1", n_to - to0); end
        dt = last_to_cycle - t_end;
        checks++; if (dt < 19 * CPB || dt > 21 * CPB) begin failures++; $display("FAIL timeout_delay: got %0d cycles, expected %0d..%0d", dt, 19 * CPB, 21 * CPB); end
        exp_q.push_back(16'h3344);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_empty(ok);
        checks++; if (!ok) begin failures++; $display("FAIL timeout_next_pair: queue size %0d, expected 0", exp_q.size()); end
        idle_bits(2);
    endtask

    task automatic test_glitch;
        int fe0, ov0, to0;
        bit ok;
        fe0 = n_fe; ov0 = n_ov; to0 = n_to;
        uart_rx = 1'b0;
        repeat (20) @(negedge sys_clk);
        idle_bits(3);
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL glitch_no_word: got valid %b, expected 0", word_valid); end
        checks++; if ((n_fe - fe0) + (n_ov - ov0) + (n_to - to0) !== 0) begin failures++; $display("FAIL glitch_pulses: got %0d, expected 0", (n_fe - fe0) + (n_ov - ov0) + (n_to - to0)); end
        exp_q.push_back(16'h5AA5);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hA5, 1'b1);
        wait_empty(ok);
        checks++; if (!ok) begin failures++; $display("FAIL glitch_next_pair: queue size %0d, expected 0", exp_q.size()); end
        idle_bits(2);
    endtask

    task automatic test_reset_mid_frame;
        logic [9:0] frame;
        bit ok;
        send_byte(8'hDE, 1'b1);
        frame = {1'b1, 8'hAD, 1'b0};
        // Reset lands mid data bit 6, after the last falling edge of the frame.
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            uart_rx = frame[i];
            if (i == 7) begin
                repeat (CPB / 2 - 1) @(negedge sys_clk);
                rst = 1'b1;
                repeat (3) @(negedge sys_clk);
                checks++; if (word_data !== 16'h0000) begin failures++; $display("FAIL midrst_word_data: got %h, expected 0000", word_data); end
                checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL midrst_word_valid: got %b, expected 0", word_valid); end
                checks++; if ({frame_err, overrun, timeout} !== 3'b000) begin failures++; $display("FAIL midrst_pulses: got %b, expected 000", {frame_err, overrun, timeout}); end
                rst = 1'b0;
                repeat (CPB / 2 - 3) @(negedge sys_clk);
            end else begin
                repeat (CPB - 1) @(negedge sys_clk);
            end
        end
        idle_bits(3);
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_word: got valid %b, expected 0", word_valid); end
        exp_q.push_back(16'hBEEF);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        wait_empty(ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_next_pair: queue size %0d, expected 0", exp_q.size()); end
        idle_bits(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Receive-side counterpart of the ADC-sample UART transmit path.
- Deserialises 8N1 UART bytes from the host and pairs them into 16-bit words, high byte first.
- Presents each completed word on a valid/ready handshake to downstream logic, such as a command decoder or the write port of a FIFO.
- Detects false starts, framing errors, inter-byte timeouts and output overrun.

Parameters:
- CLK_FREQ, 50000000: sys_clk frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated; 434 at the defaults.
- TIMEOUT_BITS, 20: bit periods allowed between the stop bit of byte 0 and the start edge of byte 1 before the partial word is discarded.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous reset, active-high.
- uart_rx  in  1  serial line; idles high; asynchronous to sys_clk.
- word_data  out  16  assembled word: {byte0, byte1}.
- word_valid  out  1  word_data holds an unconsumed word.
- word_ready  in  1  consumer accepts the word when word_valid && word_ready.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a completed word is dropped.
- timeout  out  1  one-cycle pulse when a partial word is discarded on timeout.

Behaviour:
- Reset values: word_data=0, word_valid=0, frame_err=0, overrun=0, timeout=0.
  - Synchroniser registers reset to 1.
  - Byte FSM in IDLE; pair phase = 0.
- Reset asserted mid-frame aborts the frame immediately. After release, the block waits for uart_rx high before arming.
- uart_rx passes through a 2-FF synchroniser; all decisions use the synchronised signal (rx_s).
- Byte FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a 1->0 transition on rx_s loads the bit counter and enters START.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s.
    - 0: reload the counter to CLKS_PER_BIT and enter DATA.
    - 1: false start; return to IDLE with no error pulse.
  - DATA: sample every CLKS_PER_BIT cycles. Shift the sample in LSB first. After 8 samples, enter STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - 1: byte done; one-cycle internal byte strobe; return to IDLE.
    - 0: frame_err pulse; byte discarded; pair phase cleared; enter WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s = 1, then go to IDLE.
- Pair assembly:
  - Phase 0 byte strobe: latch the byte as the high byte; phase <= 1; clear and start the timeout counter.
  - Phase 1 byte strobe: the word is complete, {high, byte}; phase <= 0.
  - While in phase 1 and the byte FSM is in IDLE, the timeout counter advances. When it reaches TIMEOUT_BITS*CLKS_PER_BIT: timeout pulse, phase <= 0, high byte discarded.
  - The counter freezes while a byte is being received.
- Output register:
  - On word complete with word_valid=0: word_data <= word; word_valid <= 1 in the cycle after the stop-bit sample.
  - Latency: 1 cycle from the stop sample of byte 1 to word_valid.
  - Handshake: word_valid falls in the cycle after word_valid && word_ready. word_data is held stable while word_valid=1.
  - Word complete while word_valid=1 and word_ready=0: the new word is dropped, the old word is retained, and overrun pulses.
  - Word complete in the same cycle as an accepting handshake: the new word is loaded, word_valid stays 1, no overrun.
- Error pulses are single-cycle and independent. Simultaneous events are impossible by construction, since only one byte completes at a time.
- Counter widths: bit counter uses $clog2(CLKS_PER_BIT); timeout counter uses $clog2(TIMEOUT_BITS*CLKS_PER_BIT+1).

Decomposition:
- Shared package uart_pkg holds:
  - the byte FSM state enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - constant function clks_per_bit(clk, baud);
  - the DATA_BITS=8 constant.
  - The transmit side reuses the same package.
- One sub-module is natural: uart_rx_byte, which contains the synchroniser, byte FSM and frame_err, and outputs byte_data[7:0] plus byte_strobe.
- uart_rx_word adds pair assembly, the timeout counter and the output register.

Test Plan:
- Send 0x12 then 0x34 back-to-back at 115200 baud with word_ready=1 -> word_data=0x1234, word_valid for 1 cycle; frame_err, overrun and timeout stay 0.
- Send 0xAB, 0xCD with word_ready=0, then 0x55, 0xAA -> word_data stays 0xABCD, overrun pulses once. Raise word_ready -> word_valid falls; the next pair 0x01, 0x02 yields 0x0102.
- Send 0x7F with the stop bit forced low, then 0x11, 0x22 -> frame_err pulses once; after the line returns high, the word is 0x1122, showing the pair phase was reset.
- Send 0x99, idle 25 bit periods, then 0x33, 0x44 -> timeout pulses ~20 bit times after 0x99; the word is 0x3344.
- Drive a 100-cycle low glitch while idle, then send 0x5A, 0xA5 -> no error pulse; the word is 0x5AA5.
- Assert rst for 3 cycles in the middle of byte 1 of 0xDE, 0xAD -> all outputs 0, no word produced; the following pair 0xBE, 0xEF yields 0xBEEF.
